// File: rtl/evu_counter_ctrl.sv
// Performance-event unit controller: NUM_CNT event counters with selectors, inhibit and overflow,
// accessed through a valid/ready register port. Optional snapshot shadows under EVU_SNAPSHOT_EN.
module evu_counter_ctrl #(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned CNT_W   = 48,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CNT-1:0]   evt_i,
  output logic [NUM_CNT*4-1:0] sel_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [7:0]           req_addr_i,
  input  logic [DATA_W-1:0]    req_wdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DATA_W-1:0]    resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 irq_o
);

  localparam int unsigned SEL_W = 4;
  localparam int unsigned IDX_W = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]         r_state;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic [DATA_W-1:0]  r_resp_rdata;
  logic               r_resp_err;
  logic               r_irq;
  logic [CNT_W-1:0]   r_cnt   [NUM_CNT];
  logic [SEL_W-1:0]   r_sel   [NUM_CNT];
  logic [1:0]         r_blank [NUM_CNT];
  logic [NUM_CNT-1:0] r_inh;
  logic [NUM_CNT-1:0] r_ovf;
`ifdef EVU_SNAPSHOT_EN
  logic [CNT_W-1:0]   r_shd   [NUM_CNT];
`endif

  logic [0:0]         w_state_nxt;
  logic               w_req_ready_nxt;
  logic               w_resp_valid_nxt;
  logic [DATA_W-1:0]  w_resp_rdata_nxt;
  logic               w_resp_err_nxt;
  logic               w_acc;
  logic               w_wr;
  logic [3:0]         w_page;
  logic [IDX_W-1:0]   w_idx;
  logic               w_idx_ok;
  logic               w_hit_cnt;
  logic               w_hit_sel;
  logic               w_hit_inh;
  logic               w_hit_ovf;
  logic               w_hit_snap;
  logic               w_hit_shd;
  logic               w_dec;
  logic [DATA_W-1:0]  w_rdata;
  logic [NUM_CNT-1:0] w_cnt_wr;
  logic [NUM_CNT-1:0] w_sel_wr;
  logic [NUM_CNT-1:0] w_inc;
  logic [NUM_CNT-1:0] w_wrap;
  logic [NUM_CNT-1:0] w_ovf_clr;
  logic               w_unused;

  assign req_ready_o  = r_req_ready;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_err_o   = r_resp_err;
  assign irq_o        = r_irq;
  assign w_unused     = ^req_wdata_i;

  // Address decode
  assign w_acc     = req_valid_i && (r_state == IDLE);
  assign w_page    = req_addr_i[7:4];
  assign w_idx     = req_addr_i[3:0];
  assign w_idx_ok  = (32'(w_idx) < NUM_CNT);
  assign w_hit_cnt = (w_page == 4'h0) && w_idx_ok;
  assign w_hit_sel = (w_page == 4'h1) && w_idx_ok;
  assign w_hit_inh = (req_addr_i == 8'h20);
  assign w_hit_ovf = (req_addr_i == 8'h21);
`ifdef EVU_SNAPSHOT_EN
  assign w_hit_snap = (req_addr_i == 8'h22);
  assign w_hit_shd  = (w_page == 4'h3) && w_idx_ok;
`else
  assign w_hit_snap = 1'b0;
  assign w_hit_shd  = 1'b0;
`endif
  assign w_dec = w_hit_cnt | w_hit_sel | w_hit_inh | w_hit_ovf | w_hit_snap | w_hit_shd;
  assign w_wr  = w_acc && req_we_i && w_dec;

  // Read mux: values present before the accepting edge
  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (w_idx == IDX_W'(i)) begin
        if (w_hit_cnt) w_rdata = DATA_W'(r_cnt[i]);
        if (w_hit_sel) w_rdata = DATA_W'(r_sel[i]);
`ifdef EVU_SNAPSHOT_EN
        if (w_hit_shd) w_rdata = DATA_W'(r_shd[i]);
`endif
      end
    end
    if (w_hit_inh) w_rdata = DATA_W'(r_inh);
    if (w_hit_ovf) w_rdata = DATA_W'(r_ovf);
  end

  // Per-counter write strobes, increment qualification and wrap detection
  always_comb begin
    w_cnt_wr  = '0;
    w_sel_wr  = '0;
    w_inc     = '0;
    w_wrap    = '0;
    w_ovf_clr = (w_wr && w_hit_ovf) ? req_wdata_i[NUM_CNT-1:0] : '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      w_cnt_wr[i] = w_wr && w_hit_cnt && (w_idx == IDX_W'(i));
      w_sel_wr[i] = w_wr && w_hit_sel && (w_idx == IDX_W'(i));
      w_inc[i]    = evt_i[i] && !r_inh[i] && (r_blank[i] == 2'd0);
      w_wrap[i]   = w_inc[i] && !w_cnt_wr[i] && (&r_cnt[i]);
    end
  end

  always_comb begin
    sel_o = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      sel_o[i*SEL_W +: SEL_W] = r_sel[i];
    end
  end

  // Request/response FSM next state and registered outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_req_ready_nxt  = r_req_ready;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_state_nxt      = RESP;
          w_req_ready_nxt  = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = (req_we_i || !w_dec) ? '0 : w_rdata;
          w_resp_err_nxt   = !w_dec;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          w_state_nxt      = IDLE;
          w_req_ready_nxt  = 1'b1;
          w_resp_valid_nxt = 1'b0;
          w_resp_rdata_nxt = '0;
          w_resp_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt      = IDLE;
        w_req_ready_nxt  = 1'b1;
        w_resp_valid_nxt = 1'b0;
        w_resp_rdata_nxt = '0;
        w_resp_err_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  // Counters, selectors, blanking, inhibit, overflow and interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inh <= '0;
      r_ovf <= '0;
      r_irq <= 1'b0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        r_cnt[i]   <= '0;
        r_sel[i]   <= '0;
        r_blank[i] <= '0;
`ifdef EVU_SNAPSHOT_EN
        r_shd[i]   <= '0;
`endif
      end
    end else begin
      if (w_wr && w_hit_inh) r_inh <= req_wdata_i[NUM_CNT-1:0];
      // A wrap on the clearing edge keeps its overflow bit set
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_wrap;
      r_irq <= |r_ovf;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (w_cnt_wr[i]) begin
          r_cnt[i] <= req_wdata_i[CNT_W-1:0];
        end else if (w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
        // Blank two edges after a selector change to skip the mux's stale registered output
        if (w_sel_wr[i]) begin
          r_sel[i]   <= req_wdata_i[SEL_W-1:0];
          r_blank[i] <= 2'd2;
        end else if (r_blank[i] != 2'd0) begin
          r_blank[i] <= r_blank[i] - 2'd1;
        end
`ifdef EVU_SNAPSHOT_EN
        if (w_wr && w_hit_snap) r_shd[i] <= r_cnt[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_evu_counter_ctrl.sv
// Directed bench for evu_counter_ctrl; snapshot checks follow EVU_SNAPSHOT_EN.
module tb_evu_counter_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  evt_i;
  logic [15:0] sel_o;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [7:0]  req_addr_i;
  logic [63:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_rdata_o;
  logic        resp_err_o;
  logic        irq_o;

  int n_vec = 0;
  int n_mis = 0;

  evu_counter_ctrl #(.NUM_CNT(4), .CNT_W(48), .DATA_W(64)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .evt_i        (evt_i),
    .sel_o        (sel_o),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [7:0] addr, input logic [63:0] wd);
    @(negedge clk_i);
    chk("req_ready_idle", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
  endtask

  task automatic complete(output logic [63:0] rd, output logic er);
    int k;
    k = 0;
    @(negedge clk_i);
    while (resp_valid_o !== 1'b1 && k < 8) begin
      @(negedge clk_i);
      k++;
    end
    chk("resp_latency", 64'(k), 64'd0);
    rd = resp_rdata_o;
    er = resp_err_o;
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [63:0] exp, input logic exp_err);
    logic [63:0] d;
    logic e;
    issue(1'b0, addr, 64'd0);
    complete(d, e);
    chk(tag, d, exp);
    chk({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  task automatic wr(input string tag, input logic [7:0] addr, input logic [63:0] data, input logic exp_err);
    logic [63:0] d;
    logic e;
    issue(1'b1, addr, data);
    complete(d, e);
    chk({tag, "_wrdata"}, d, 64'd0);
    chk({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  initial begin
    logic [63:0] d;
    logic e;
    rst_i = 1'b1; evt_i = '0; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; resp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_rdata", resp_rdata_o, 64'd0);
    chk("rst_resp_err", 64'(resp_err_o), 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_sel", 64'(sel_o), 64'd0);
    rst_i = 1'b0;

    // 1: read after reset
    rd_chk("t1_cnt0", 8'h00, 64'd0, 1'b0);
    chk("t1_irq", 64'(irq_o), 64'd0);

    // 2: selector write with event held 10 edges from the write edge; 2 blanked
    evt_i = 4'b0001;
    issue(1'b1, 8'h10, 64'h3);
    complete(d, e);
    repeat (8) @(posedge clk_i);
    #1 evt_i = '0;
    chk("t2_sel_o", 64'(sel_o), 64'h0003);
    rd_chk("t2_cnt0", 8'h00, 64'd8, 1'b0);
    rd_chk("t2_sel_rd", 8'h10, 64'd3, 1'b0);

    // 3: wrap sets overflow and irq, W1C clears
    wr("t3_wr", 8'h00, 64'h0000_FFFF_FFFF_FFFE, 1'b0);
    evt_i = 4'b0001;
    repeat (3) @(posedge clk_i);
    #1 evt_i = '0;
    chk("t3_irq_set", 64'(irq_o), 64'd1);
    rd_chk("t3_cnt0", 8'h00, 64'd1, 1'b0);
    rd_chk("t3_ovf", 8'h21, 64'h1, 1'b0);
    wr("t3_w1c", 8'h21, 64'h1, 1'b0);
    chk("t3_irq_clr", 64'(irq_o), 64'd0);
    rd_chk("t3_ovf_clr", 8'h21, 64'h0, 1'b0);

    // 4: write beats same-edge increment; inhibit applies from the next edge
    evt_i = 4'b0010;
    issue(1'b1, 8'h01, 64'd100);
    evt_i = '0;
    complete(d, e);
    rd_chk("t4_cnt1", 8'h01, 64'd100, 1'b0);
    evt_i = 4'b0010;
    issue(1'b1, 8'h20, 64'h2);
    complete(d, e);
    repeat (3) @(posedge clk_i);
    #1 evt_i = '0;
    rd_chk("t4_cnt1_inh", 8'h01, 64'd101, 1'b0);
    rd_chk("t4_inh_rd", 8'h20, 64'h2, 1'b0);

    // 5: undecoded addresses and a stalled response
    issue(1'b0, 8'h40, 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("t5_hold_valid", 64'(resp_valid_o), 64'd1);
      chk("t5_hold_ready", 64'(req_ready_o), 64'd0);
      chk("t5_hold_rdata", resp_rdata_o, 64'd0);
      chk("t5_hold_err", 64'(resp_err_o), 64'd1);
    end
    complete(d, e);
    chk("t5_rdata", d, 64'd0);
    chk("t5_err", 64'(e), 64'd1);
    rd_chk("t5_idx_oob", 8'h04, 64'd0, 1'b1);
    wr("t5_sel_oob", 8'h14, 64'h5, 1'b1);
    chk("t5_sel_keep", 64'(sel_o), 64'h0003);

    // Truncated counter write and inhibit release
    wr("trunc_wr", 8'h02, 64'hABCD_0000_0000_0005, 1'b0);
    rd_chk("trunc_rd", 8'h02, 64'd5, 1'b0);
    wr("inh_clr", 8'h20, 64'h0, 1'b0);

    // 6: snapshot
    wr("t6_c0", 8'h00, 64'd5, 1'b0);
    wr("t6_c1", 8'h01, 64'd7, 1'b0);
`ifdef EVU_SNAPSHOT_EN
    wr("t6_snap", 8'h22, 64'h0, 1'b0);
    evt_i = 4'b0011;
    repeat (4) @(posedge clk_i);
    #1 evt_i = '0;
    rd_chk("t6_shd0", 8'h30, 64'd5, 1'b0);
    rd_chk("t6_shd1", 8'h31, 64'd7, 1'b0);
    rd_chk("t6_live0", 8'h00, 64'd9, 1'b0);
    rd_chk("t6_live1", 8'h01, 64'd11, 1'b0);
`else
    rd_chk("t6_snap_off", 8'h22, 64'd0, 1'b1);
    rd_chk("t6_shd_off", 8'h30, 64'd0, 1'b1);
`endif

    // Reset while a response is pending
    wr("rst_pre", 8'h03, 64'h0000_FFFF_FFFF_FFFF, 1'b0);
    evt_i = 4'b1000;
    @(posedge clk_i);
    #1 evt_i = '0;
    @(posedge clk_i);
    #1;
    chk("rst_pre_irq", 64'(irq_o), 64'd1);
    issue(1'b0, 8'h00, 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_valid", 64'(resp_valid_o), 64'd0);
    chk("mid_rst_ready", 64'(req_ready_o), 64'd1);
    chk("mid_rst_irq", 64'(irq_o), 64'd0);
    chk("mid_rst_sel", 64'(sel_o), 64'd0);
    rd_chk("mid_rst_cnt0", 8'h00, 64'd0, 1'b0);
    rd_chk("mid_rst_ovf", 8'h21, 64'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
